// File: rtl/a25_cache_flush_ctrl.sv
// Cache flush sequencer: sweeps every tag RAM line on a CP15 flush strobe and registers the cacheable qualifier.
// Optional: define A25_FLUSH_ON_RESET_EN to start a full invalidate sweep straight out of reset.
module a25_cache_flush_ctrl #(
    parameter int CACHE_LINES = 256,
    parameter int CACHE_WAYS  = 4,
    localparam int LW         = $clog2(CACHE_LINES)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_access_stall,
    input  logic                  i_cache_flush,
    input  logic                  i_cache_enable,
    input  logic [31:0]           i_cacheable_area,
    input  logic [31:0]           i_address,
    input  logic                  i_address_valid,
    output logic                  o_cacheable,
    output logic                  o_flush_busy,
    output logic                  o_flush_done,
    output logic                  o_tag_wenable,
    output logic [CACHE_WAYS-1:0] o_tag_way_sel,
    output logic [LW-1:0]         o_tag_addr
);

    typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

`ifdef A25_FLUSH_ON_RESET_EN
    localparam state_t RESET_STATE = FLUSH;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    localparam logic [LW-1:0] LAST_LINE = LW'(CACHE_LINES - 1);

    // state is left visible for bound checkers
    state_t        state;
    state_t        state_next;
    logic [LW-1:0] count;
    logic [LW-1:0] count_next;
    logic          area_hit;
    logic          unused_addr;

    assign unused_addr = ^{i_address[31:26], i_address[20:0]};
    assign area_hit    = i_cacheable_area[i_address[25:21]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= RESET_STATE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // A stalled cycle holds everything; a flush strobe always restarts the sweep from line 0.
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (i_cache_flush && !i_access_stall) begin
                    state_next = FLUSH;
                    count_next = '0;
                end
            end
            FLUSH: begin
                if (!i_access_stall) begin
                    if (i_cache_flush) begin
                        count_next = '0;
                    end else if (count == LAST_LINE) begin
                        state_next = DONE;
                        count_next = '0;
                    end else begin
                        count_next = count + 1'b1;
                    end
                end
            end
            DONE: begin
                if (!i_access_stall) begin
                    state_next = i_cache_flush ? FLUSH : IDLE;
                    count_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cacheable <= 1'b0;
        end else if (!i_access_stall) begin
            o_cacheable <= i_address_valid && i_cache_enable && area_hit && (state_next == IDLE);
        end
    end

    // Write strobe is masked while reset is held so a flush-on-reset build still shows idle tag outputs.
    assign o_flush_busy  = (state != IDLE);
    assign o_flush_done  = (state == DONE);
    assign o_tag_wenable = (state == FLUSH) && !i_access_stall && !i_rst;
    assign o_tag_way_sel = {CACHE_WAYS{o_tag_wenable}};
    assign o_tag_addr    = count;

endmodule

// File: tb/tb_a25_cache_flush_ctrl.sv
// Self-checking bench for a25_cache_flush_ctrl with 8 lines x 4 ways; follows A25_FLUSH_ON_RESET_EN if defined.
module tb_a25_cache_flush_ctrl;

    localparam int L  = 8;
    localparam int W  = 4;
    localparam int LW = 3;

`ifdef A25_FLUSH_ON_RESET_EN
    localparam int RESET_POS = 0;
`else
    localparam int RESET_POS = -1;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_access_stall;
    logic          i_cache_flush;
    logic          i_cache_enable;
    logic [31:0]   i_cacheable_area;
    logic [31:0]   i_address;
    logic          i_address_valid;
    logic          o_cacheable;
    logic          o_flush_busy;
    logic          o_flush_done;
    logic          o_tag_wenable;
    logic [W-1:0]  o_tag_way_sel;
    logic [LW-1:0] o_tag_addr;

    a25_cache_flush_ctrl #(.CACHE_LINES(L), .CACHE_WAYS(W)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_access_stall   (i_access_stall),
        .i_cache_flush    (i_cache_flush),
        .i_cache_enable   (i_cache_enable),
        .i_cacheable_area (i_cacheable_area),
        .i_address        (i_address),
        .i_address_valid  (i_address_valid),
        .o_cacheable      (o_cacheable),
        .o_flush_busy     (o_flush_busy),
        .o_flush_done     (o_flush_done),
        .o_tag_wenable    (o_tag_wenable),
        .o_tag_way_sel    (o_tag_way_sel),
        .o_tag_addr       (o_tag_addr)
    );

    always #5 i_clk = ~i_clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference: pos = -1 idle, 0..L-1 line being invalidated, L = completion cycle.
    int   pos;
    logic exp_cache;
    logic [LW-1:0] exp_q[$];

    wire [10:0] obs = {o_flush_busy, o_flush_done, o_tag_wenable, o_tag_way_sel, o_tag_addr, o_cacheable};

    function automatic logic [10:0] model_out();
        logic          busy, done, wen;
        logic [W-1:0]  way;
        logic [LW-1:0] addr;
        int            p;
        p    = pos;
        busy = (p >= 0);
        done = (p == L);
        wen  = (p >= 0) && (p < L) && !i_access_stall && !i_rst;
        way  = wen ? {W{1'b1}} : '0;
        addr = ((p >= 0) && (p < L)) ? LW'(p) : '0;
        return {busy, done, wen, way, addr, exp_cache};
    endfunction

    task automatic drive(input logic f, input logic s, input logic v, input logic [31:0] a,
                         input logic en, input logic [31:0] area);
        @(negedge i_clk);
        i_cache_flush    = f;
        i_access_stall   = s;
        i_address_valid  = v;
        i_address        = a;
        i_cache_enable   = en;
        i_cacheable_area = area;
        #1;
    endtask

    task automatic advance();
        int nxt;
        if (!i_access_stall) begin
            if (i_cache_flush)             nxt = 0;
            else if (pos >= 0 && pos < L)  nxt = pos + 1;
            else                           nxt = -1;
            exp_cache = i_address_valid && i_cache_enable &&
                        i_cacheable_area[i_address[25:21]] && (nxt == -1);
            pos = nxt;
        end
        @(posedge i_clk);
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_cache_flush = 0; i_access_stall = 0; i_address_valid = 0;
        i_address = 0; i_cache_enable = 0; i_cacheable_area = 0;
        pos = RESET_POS;
        exp_cache = 1'b0;
        #1;
        compared++;
        if (obs !== model_out()) begin
            mismatched++;
            $display("FAIL reset_values: got %h expected %h", obs, model_out());
        end
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int k = 0; k < L + 3; k++) begin
            drive(0, 0, 0, 32'h0, 0, 32'h0);
            compared++;
            if (obs !== model_out()) begin
                mismatched++;
                $display("FAIL reset_release cyc%0d: got %h expected %h", k, obs, model_out());
            end
            advance();
        end
    endtask

    task automatic test_single_flush();
        int done_cnt = 0;
        int done_at  = -1;
        exp_q.delete();
        for (int i = 0; i < L; i++) exp_q.push_back(LW'(i));
        for (int k = 0; k < 12; k++) begin
            drive(k == 0, 0, 0, 32'h0, 1, 32'h0);
            compared++;
            if (obs !== model_out()) begin
                mismatched++;
                $display("FAIL single_flush cyc%0d: got %h expected %h", k, obs, model_out());
            end
            if (o_tag_wenable === 1'b1) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL single_extra_write: got addr %0d expected none", o_tag_addr);
                end else if (o_tag_addr !== exp_q.pop_front()) begin
                    mismatched++;
                    $display("FAIL single_write_order: got addr %0d cyc%0d", o_tag_addr, k);
                end
            end
            if (o_flush_done === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            advance();
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL single_missing_writes: got %0d left expected 0", exp_q.size());
        end
        compared++;
        if (done_cnt != 1 || done_at != L + 1) begin
            mismatched++;
            $display("FAIL single_done: got %0d pulses at %0d expected 1 at %0d", done_cnt, done_at, L + 1);
        end
    endtask

    task automatic test_stall_flush();
        int done_at = -1;
        for (int k = 0; k < 16; k++) begin
            drive(k == 0, (k >= 5 && k < 8), 0, 32'h0, 1, 32'h0);
            compared++;
            if (obs !== model_out()) begin
                mismatched++;
                $display("FAIL stall_flush cyc%0d: got %h expected %h", k, obs, model_out());
            end
            if (k >= 5 && k < 8) begin
                compared++;
                if (o_tag_addr !== 3'd4 || o_tag_wenable !== 1'b0) begin
                    mismatched++;
                    $display("FAIL stall_hold cyc%0d: got addr %0d wen %b expected 4 0", k, o_tag_addr, o_tag_wenable);
                end
            end
            if (o_flush_done === 1'b1) done_at = k;
            advance();
        end
        compared++;
        if (done_at != L + 1 + 3) begin
            mismatched++;
            $display("FAIL stall_done_delay: got %0d expected %0d", done_at, L + 4);
        end
    endtask

    task automatic test_restart();
        int done_cnt = 0;
        int writes   = 0;
        for (int k = 0; k < 18; k++) begin
            drive(k == 0 || k == 6, 0, 0, 32'h0, 1, 32'h0);
            compared++;
            if (obs !== model_out()) begin
                mismatched++;
                $display("FAIL restart cyc%0d: got %h expected %h", k, obs, model_out());
            end
            if (k == 6) begin
                compared++;
                if (o_tag_addr !== 3'd5) begin
                    mismatched++;
                    $display("FAIL restart_point: got addr %0d expected 5", o_tag_addr);
                end
            end
            if (o_tag_wenable === 1'b1) writes++;
            if (o_flush_done === 1'b1) done_cnt++;
            advance();
        end
        compared++;
        if (writes != 6 + L || done_cnt != 1) begin
            mismatched++;
            $display("FAIL restart_totals: got %0d writes %0d done expected %0d 1", writes, done_cnt, 6 + L);
        end
    endtask

    task automatic test_cacheable();
        logic [31:0] addrs [5] = '{32'h0020_0000, 32'h0040_0000, 32'h0020_0000, 32'hFC20_0000, 32'h0020_0000};
        logic        ens   [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic        vals  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        exps  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, vals[i], addrs[i], ens[i], 32'h0000_0002);
            advance();
            #1;
            compared++;
            if (o_cacheable !== exps[i]) begin
                mismatched++;
                $display("FAIL cacheable_vec%0d: got %b expected %b", i, o_cacheable, exps[i]);
            end
        end
        drive(1, 0, 1, 32'h0020_0000, 1, 32'h0000_0002);
        advance();
        #1;
        compared++;
        if (o_cacheable !== 1'b0) begin
            mismatched++;
            $display("FAIL cacheable_in_flush: got %b expected 0", o_cacheable);
        end
        for (int k = 0; k < L + 2; k++) begin
            drive(0, 0, 1, 32'h0020_0000, 1, 32'h0000_0002);
            compared++;
            if (obs !== model_out()) begin
                mismatched++;
                $display("FAIL cacheable_flush cyc%0d: got %h expected %h", k, obs, model_out());
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0, 1'($urandom),
                  $urandom, $urandom_range(0, 3) != 0, $urandom);
            compared++;
            if (obs !== model_out()) begin
                mismatched++;
                $display("FAIL random cyc%0d: got %h expected %h", k, obs, model_out());
            end
            advance();
        end
        for (int k = 0; k < 4 * L && pos != -1; k++) begin
            drive(0, $urandom_range(0, 3) == 0, 0, 32'h0, 1, 32'h0);
            compared++;
            if (obs !== model_out()) begin
                mismatched++;
                $display("FAIL random_drain cyc%0d: got %h expected %h", k, obs, model_out());
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        int done_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            drive(k == 0, 0, 0, 32'h0, 1, 32'h0);
            compared++;
            if (obs !== model_out()) begin
                mismatched++;
                $display("FAIL pre_reset cyc%0d: got %h expected %h", k, obs, model_out());
            end
            if (o_flush_done === 1'b1) done_cnt++;
            if (k < 4) advance();
        end
        #2;
        i_rst = 1'b1;
        pos = RESET_POS;
        exp_cache = 1'b0;
        #1;
        compared++;
        if (obs !== model_out()) begin
            mismatched++;
            $display("FAIL async_reset: got %h expected %h", obs, model_out());
        end
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int k = 0; k < L + 3; k++) begin
            drive(0, 0, 0, 32'h0, 1, 32'h0);
            compared++;
            if (obs !== model_out()) begin
                mismatched++;
                $display("FAIL post_reset cyc%0d: got %h expected %h", k, obs, model_out());
            end
            if (o_flush_done === 1'b1) done_cnt++;
            advance();
        end
        compared++;
        if (done_cnt != (RESET_POS == 0 ? 1 : 0)) begin
            mismatched++;
            $display("FAIL reset_done_count: got %0d expected %0d", done_cnt, (RESET_POS == 0 ? 1 : 0));
        end
    endtask

    initial begin
        test_reset();
        test_single_flush();
        test_stall_flush();
        test_restart();
        test_cacheable();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
